// File: rtl/reg_display_mux.sv
// reg_display_mux: watches a window of register-file writes, holds the last
// value written to each watched register, and scans one of them onto a
// multiplexed active-low 7-segment display. The decimal point on digit 0
// flashes for a while after a capture lands on the channel being shown.
module reg_display_mux #(
    parameter int NUM_CH      = 2,
    parameter int WATCH_BASE  = 11,
    parameter int DATA_W      = 32,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int FLASH_CYC   = 25000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_we,
    input  logic [3:0]        reg_rd,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              ch_next,
    input  logic              half_sel,
    input  logic              freeze,
    output logic [CH_W-1:0]   ch,
    output logic [DIGITS-1:0] anode,
    output logic [7:0]        catode
);

    localparam int PS_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FL_W = $clog2(FLASH_CYC + 1);

    logic [DATA_W-1:0]   cap [NUM_CH];
    logic [PS_W-1:0]     presc;
    logic [DG_W-1:0]     dig;
    logic [FL_W-1:0]     flash;

    logic [4:0]          rd_ext;
    logic [4:0]          rd_off;
    logic [CH_W-1:0]     cap_idx;
    logic                hit;
    logic [CH_W-1:0]     ch_nxt;
    logic [FL_W-1:0]     flash_nxt;
    logic                presc_wrap;
    logic [DATA_W-1:0]   cur;
    logic [4*DIGITS-1:0] word;
    logic [3:0]          nibble;
    logic                dp_n;

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Decode capture hit, next channel, next flash count and the shown nibble
    always_comb begin
        rd_ext     = {1'b0, reg_rd};
        rd_off     = rd_ext - 5'(WATCH_BASE);
        cap_idx    = rd_off[CH_W-1:0];
        hit        = reg_we && !freeze &&
                     (rd_ext >= 5'(WATCH_BASE)) &&
                     (rd_ext <  5'(WATCH_BASE + NUM_CH));

        ch_nxt = ch;
        if (ch_next)
            ch_nxt = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;

        // The flash compares against the channel as it will be after this edge,
        // so a capture landing together with ch_next flashes the new channel.
        flash_nxt = flash;
        if (hit && (cap_idx == ch_nxt))
            flash_nxt = FL_W'(FLASH_CYC);
        else if (ch_next)
            flash_nxt = '0;
        else if (flash != '0)
            flash_nxt = flash - 1'b1;

        presc_wrap = (presc == PS_W'(REFRESH_DIV - 1));

        cur    = cap[ch];
        word   = half_sel ? cur[8*DIGITS-1:4*DIGITS] : cur[4*DIGITS-1:0];
        nibble = word[{dig, 2'b00} +: 4];
        dp_n   = !((dig == '0) && (flash != '0));
    end

    // Capture registers, displayed channel and flash counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                cap[i] <= '0;
            ch    <= '0;
            flash <= '0;
        end else begin
            if (hit)
                cap[cap_idx] <= reg_data;
            ch    <= ch_nxt;
            flash <= flash_nxt;
        end
    end

    // Refresh prescaler steps the scanned digit once per slot
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            dig   <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
            dig   <= (dig == DG_W'(DIGITS - 1)) ? '0 : dig + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Register the pins so anode and segments always change together
    always_ff @(posedge clk) begin
        if (reset) begin
            anode  <= '1;
            catode <= 8'hFF;
        end else begin
            anode  <= ~(DIGITS'(1) << dig);
            catode <= {dp_n, seg7(nibble)};
        end
    end

endmodule

// File: tb/tb_reg_display_mux.sv
// tb_reg_display_mux: directed test of capture, channel stepping, digit scan,
// decimal-point flash, freeze/out-of-range filtering and synchronous reset.
module tb_reg_display_mux;

    logic        clk;
    logic        reset;
    logic        reg_we;
    logic [3:0]  reg_rd;
    logic [31:0] reg_data;
    logic        ch_next;
    logic        half_sel;
    logic        freeze;
    logic [0:0]  ch;
    logic [3:0]  anode;
    logic [7:0]  catode;

    int vecCount;
    int missCount;
    int edgeCnt;

    reg_display_mux #(
        .NUM_CH(2),
        .WATCH_BASE(11),
        .DATA_W(32),
        .DIGITS(4),
        .REFRESH_DIV(4),
        .FLASH_CYC(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reg_we(reg_we),
        .reg_rd(reg_rd),
        .reg_data(reg_data),
        .ch_next(ch_next),
        .half_sel(half_sel),
        .freeze(freeze),
        .ch(ch),
        .anode(anode),
        .catode(catode)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        edgeCnt++;
    endtask

    // Step until the given edge count since reset release
    task automatic runTo(input int n);
        while (edgeCnt < n)
            applyStimulus();
    endtask

    // Count one comparison and report a miscompare
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, want %h (edge %0d)", tag, got, want, edgeCnt);
        end
    endtask

    // Directed sequence; edge numbers count from reset release
    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        reg_we    = 1'b0;
        reg_rd    = 4'd0;
        reg_data  = 32'h0;
        ch_next   = 1'b0;
        half_sel  = 1'b0;
        freeze    = 1'b0;
        vecCount  = 0;
        missCount = 0;
        edgeCnt   = 0;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_anode", 32'(anode), 32'hF);
        checkOutput("rst_catode", 32'(catode), 32'hFF);
        checkOutput("rst_ch", 32'(ch), 32'h0);

        reset   = 1'b0;
        edgeCnt = 0;

        // Scan after release: four edges per digit
        applyStimulus();
        checkOutput("e1_anode", 32'(anode), 32'hE);
        checkOutput("e1_catode", 32'(catode), 32'hC0);
        runTo(4);
        checkOutput("e4_anode", 32'(anode), 32'hE);
        runTo(5);
        checkOutput("e5_anode", 32'(anode), 32'hD);
        runTo(9);
        checkOutput("e9_anode", 32'(anode), 32'hB);
        runTo(13);
        checkOutput("e13_anode", 32'(anode), 32'h7);

        // Capture R11 = 0x1234 just before a digit-0 slot
        runTo(15);
        reg_we   = 1'b1;
        reg_rd   = 4'd11;
        reg_data = 32'h0000_1234;
        applyStimulus();
        reg_we   = 1'b0;
        applyStimulus();
        checkOutput("e17_anode", 32'(anode), 32'hE);
        checkOutput("e17_dig0_dp", 32'(catode), 32'h19);
        runTo(20);
        checkOutput("e20_dig0_dp", 32'(catode), 32'h19);
        runTo(21);
        checkOutput("e21_anode", 32'(anode), 32'hD);
        checkOutput("e21_dig1", 32'(catode), 32'hB0);
        runTo(25);
        checkOutput("e25_dig2", 32'(catode), 32'hA4);
        runTo(29);
        checkOutput("e29_dig3", 32'(catode), 32'hF9);
        runTo(33);
        checkOutput("e33_dp_off", 32'(catode), 32'h99);

        // R12 = 0xABCD_0000, switch to channel 1 upper half
        reg_we   = 1'b1;
        reg_rd   = 4'd12;
        reg_data = 32'hABCD_0000;
        applyStimulus();
        reg_we   = 1'b0;
        ch_next  = 1'b1;
        half_sel = 1'b1;
        applyStimulus();
        ch_next  = 1'b0;
        checkOutput("e35_ch", 32'(ch), 32'h1);
        applyStimulus();
        checkOutput("e36_ch1_d", 32'(catode), 32'hA1);
        applyStimulus();
        checkOutput("e37_ch1_c", 32'(catode), 32'hC6);
        runTo(41);
        checkOutput("e41_ch1_b", 32'(catode), 32'h83);
        runTo(45);
        checkOutput("e45_ch1_a", 32'(catode), 32'h88);

        // Load flash on channel 1, then ch_next wraps to 0 and clears it
        reg_we   = 1'b1;
        applyStimulus();
        reg_we   = 1'b0;
        ch_next  = 1'b1;
        applyStimulus();
        ch_next  = 1'b0;
        checkOutput("e47_ch_wrap", 32'(ch), 32'h0);
        runTo(49);
        checkOutput("e49_flash_clr", 32'(catode), 32'hC0);
        runTo(52);
        half_sel = 1'b0;
        applyStimulus();
        checkOutput("e53_half_lo", 32'(catode), 32'hB0);

        // Frozen write, then writes just below and just above the window
        freeze   = 1'b1;
        reg_we   = 1'b1;
        reg_rd   = 4'd11;
        reg_data = 32'h0000_FFFF;
        applyStimulus();
        freeze   = 1'b0;
        reg_rd   = 4'd10;
        reg_data = 32'h0000_5555;
        applyStimulus();
        reg_rd   = 4'd13;
        applyStimulus();
        reg_we   = 1'b0;
        applyStimulus();
        checkOutput("e57_frozen", 32'(catode), 32'hA4);
        runTo(65);
        checkOutput("e65_no_flash", 32'(catode), 32'h99);
        ch_next  = 1'b1;
        half_sel = 1'b1;
        applyStimulus();
        ch_next  = 1'b0;
        checkOutput("e66_ch", 32'(ch), 32'h1);
        runTo(69);
        checkOutput("e69_ch1_kept", 32'(catode), 32'hC6);

        // Back to channel 0, then capture and ch_next on the same edge
        runTo(76);
        ch_next  = 1'b1;
        applyStimulus();
        ch_next  = 1'b0;
        checkOutput("e77_ch", 32'(ch), 32'h0);
        runTo(79);
        reg_we   = 1'b1;
        reg_rd   = 4'd12;
        reg_data = 32'h0000_0007;
        ch_next  = 1'b1;
        half_sel = 1'b0;
        applyStimulus();
        reg_we   = 1'b0;
        ch_next  = 1'b0;
        checkOutput("e80_ch", 32'(ch), 32'h1);
        applyStimulus();
        checkOutput("e81_same_edge", 32'(catode), 32'h78);
        applyStimulus();
        checkOutput("e82_same_edge", 32'(catode), 32'h78);

        // Reset mid-scan wins over a concurrent capture and ch_next
        reset    = 1'b1;
        reg_we   = 1'b1;
        reg_rd   = 4'd11;
        reg_data = 32'h0000_FFFF;
        ch_next  = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_anode", 32'(anode), 32'hF);
        checkOutput("mid_rst_catode", 32'(catode), 32'hFF);
        checkOutput("mid_rst_ch", 32'(ch), 32'h0);
        reset    = 1'b0;
        reg_we   = 1'b0;
        ch_next  = 1'b0;
        edgeCnt  = 0;
        applyStimulus();
        checkOutput("r1_anode", 32'(anode), 32'hE);
        checkOutput("r1_catode", 32'(catode), 32'hC0);
        ch_next  = 1'b1;
        applyStimulus();
        ch_next  = 1'b0;
        applyStimulus();
        checkOutput("r3_cap1_clr", 32'(catode), 32'hC0);
        applyStimulus();
        checkOutput("r4_anode", 32'(anode), 32'hE);
        applyStimulus();
        checkOutput("r5_anode", 32'(anode), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/reg_display_mux.md
REG_DISPLAY_MUX -- requirements
Module: reg_display_mux

Interface
REQ-001 Parameter NUM_CH, default 2: number of consecutive watched registers (1..16).
REQ-002 Parameter WATCH_BASE, default 11: register index of channel 0; WATCH_BASE+NUM_CH SHALL be <= 16.
REQ-003 Parameter DATA_W, default 32: register write-data width; SHALL be >= 8*DIGITS.
REQ-004 Parameter DIGITS, default 4: number of 7-segment digits scanned.
REQ-005 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot (>= 1).
REQ-006 Parameter FLASH_CYC, default 25000000: cycles the capture indicator stays lit (>= 1).
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 reg_we  in  1  register-file write strobe (RegWrite).
REQ-010 reg_rd  in  4  destination register index (Rd).
REQ-011 reg_data  in  DATA_W  value being written.
REQ-012 ch_next  in  1  one-cycle pulse; advance displayed channel.
REQ-013 half_sel  in  1  0 = show bits [4*DIGITS-1:0], 1 = bits [8*DIGITS-1:4*DIGITS].
REQ-014 freeze  in  1  high = suppress all captures.
REQ-015 ch  out  max(1,clog2(NUM_CH))  currently displayed channel.
REQ-016 anode  out  DIGITS  active-low digit enable, registered.
REQ-017 catode  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.

Function
REQ-018 Capture: on an edge with reg_we=1, freeze=0, WATCH_BASE <= reg_rd < WATCH_BASE+NUM_CH, cap[reg_rd-WATCH_BASE] SHALL load reg_data; all other cap entries hold.
REQ-019 Writes outside the watched range, or with freeze=1, SHALL change no cap entry and no flash state.
REQ-020 Channel: ch_next=1 SHALL set ch <= (ch==NUM_CH-1) ? 0 : ch+1; ch_next=0 holds ch.
REQ-021 Capture and ch_next on the same edge SHALL both take effect.
REQ-022 Prescaler counts 0..REFRESH_DIV-1 and wraps; on the wrap edge, digit index dig SHALL advance modulo DIGITS.
REQ-023 Displayed word W = cap[ch] slice chosen by half_sel; nibble shown at dig = W[4*dig+3:4*dig].
REQ-024 Each edge, anode SHALL register ~(1<<dig) and catode SHALL register the encoding of the current nibble/dp (one-cycle latency from state to pins).
REQ-025 catode[6:0] encodings, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex, bit7 shown as 1).
REQ-026 catode[7] (dp) SHALL be 0 only when dig==0 and flash counter != 0; otherwise 1.
REQ-027 Flash counter: load FLASH_CYC when a capture targets the channel equal to ch after this edge's update; else if ch_next=1 clear to 0; else decrement, saturating at 0.
REQ-028 half_sel and ch changes SHALL be visible on catode on the edge after they take effect; no blanking cycle.

Reset
REQ-029 reset=1 at an edge SHALL set all cap entries, ch, dig, prescaler and flash counter to 0, anode to all ones, catode to 8'hFF.
REQ-030 reset SHALL take priority over capture and ch_next on the same edge, including mid-scan.
REQ-031 First edge after reset release: anode = ~1 (e.g. 4'b1110), catode = 8'hC0.

Verification (NUM_CH=2, WATCH_BASE=11, DIGITS=4, REFRESH_DIV=4, FLASH_CYC=8)
REQ-032 Reset, release -> anode 1110, catode C0; anode steps 1101,1011,0111,1110 every 4 cycles.
REQ-033 Write R11=0x0000_1234 -> digits 0..3 show 4,3,2,1 (99,B0,A4,F9); dp low on digit 0 for 8 cycles, then high.
REQ-034 Write R12=0xABCD_0000, pulse ch_next, half_sel=1 -> ch=1, digits show D,C,B,A; second ch_next -> ch=0 (wrap), flash cleared.
REQ-035 freeze=1 with write R11=0xFFFF, and write R10=0x5555 with freeze=0 -> cap unchanged, no dp flash.
REQ-036 Same-edge write R12=0x7 and ch_next from ch=0 -> ch=1, cap[1]=7, flash loaded; reset asserted mid-scan -> REQ-029 values next edge.
